// File: rtl/conf_bank_pkg.sv
// ============================================================================
// Module      : conf_bank_pkg
// Description : Shared constants for the configuration register bank:
//               digit count, entry count, binary width, reset defaults,
//               clamp limits and converter FSM state encodings.
//               The clamp limits only matter when CONF_BANK_RANGE_EN is
//               defined at compile time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conf_bank_pkg;

  localparam int UNIT_BCD_W   = 6;   // BCD digits per entry
  localparam int CONF_NUM_DEF = 5;   // number of entries
  localparam int CONF_BIN_W   = 20;  // binary copy width, holds 999999
  localparam int IDX_W        = 3;   // width of the entry index port

  // Reset contents; element k is entry k.
  localparam logic [CONF_NUM_DEF-1:0][4*UNIT_BCD_W-1:0] CONF_DEFAULT = {
    24'h000007, 24'h000003, 24'h000001, 24'h000003, 24'h000100
  };

  // Per-entry clamp window (BCD words, compared as raw unsigned values).
  localparam logic [CONF_NUM_DEF-1:0][4*UNIT_BCD_W-1:0] CONF_MIN = {
    24'h000001, 24'h000001, 24'h000001, 24'h000001, 24'h000001
  };
  localparam logic [CONF_NUM_DEF-1:0][4*UNIT_BCD_W-1:0] CONF_MAX = {
    24'h000050, 24'h000020, 24'h000020, 24'h000050, 24'h001000
  };

  // Converter FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_CONV   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // True when a nibble is a legal decimal digit.
  function automatic logic nib_is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conf_bank_bcd_to_bin_seq.sv
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential BCD-to-binary converter, one digit per cycle,
//               most significant digit first (acc = acc*10 + digit).
// Ports       : clk, rst_n (async, active-low), ce (clock enable)
//               start  - load bcd into the shift register, clear acc
//               bcd    - BCD word to convert
//               done   - high during the final conversion step
//               bin    - accumulator; holds the result after done
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic [BIN_W-1:0]      bin
);

  localparam int             CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] shreg;
  logic [BIN_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                busy;
  logic [3:0]          digit;
  logic [BIN_W-1:0]    acc_step;

  assign digit    = shreg[4*DIGITS-1 -: 4];
  // x*10 as two shifts and an add, wrapping at BIN_W bits
  assign acc_step = (acc << 3) + (acc << 1) + BIN_W'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (ce) begin
      if (start) begin
        shreg <= bcd;
        acc   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc   <= acc_step;
        shreg <= shreg << 4;
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
        end
      end
    end
  end

  assign done = busy && (cnt == LAST);
  assign bin  = acc;

endmodule

`default_nettype wire

// File: rtl/conf_bank.sv
// ============================================================================
// Module      : conf_bank
// Description : Configuration register bank. Stores one BCD word per entry,
//               serves registered reads, validates writes, and keeps a
//               background-converted binary copy of every entry.
//               Compile-time option: CONF_BANK_RANGE_EN clamps accepted
//               writes into [CONF_MIN[k], CONF_MAX[k]].
// Ports       : clk, rst_n (async, active-low), ce (clock enable)
//               conf_selected_index     - entry for read/write
//               conf_selected_value     - registered BCD read data
//               conf_selected_new_value - write data
//               conf_selected_set       - write strobe
//               conf_bin                - flat binary copies
//               conf_valid              - all binary copies up to date
//               conf_err                - sticky rejected-write flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conf_bank
  import conf_bank_pkg::*;
#(
  parameter int CONF_NUM   = CONF_NUM_DEF,
  parameter int BCD_DIGITS = UNIT_BCD_W,
  parameter int BIN_W      = CONF_BIN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic [IDX_W-1:0]          conf_selected_index,
  output logic [4*BCD_DIGITS-1:0]   conf_selected_value,
  input  logic [4*BCD_DIGITS-1:0]   conf_selected_new_value,
  input  logic                      conf_selected_set,
  output logic [CONF_NUM*BIN_W-1:0] conf_bin,
  output logic                      conf_valid,
  output logic                      conf_err
);

  localparam int WORD_W = 4 * BCD_DIGITS;

  logic [CONF_NUM-1:0][WORD_W-1:0] bcd_mem;
  logic [CONF_NUM-1:0][BIN_W-1:0]  bin_mem;
  logic [CONF_NUM-1:0]             dirty;
  logic [IDX_W-1:0]                cur_idx;
  logic [1:0]                      state;
  logic [1:0]                      state_next;

  logic                            idx_legal;
  logic                            nibbles_ok;
  logic                            wr_accept;
  logic [IDX_W-1:0]                wr_idx;
  logic [WORD_W-1:0]               store_val;
  logic [IDX_W-1:0]                pick_idx;
  logic                            conv_start;
  logic                            conv_done;
  logic                            do_pick;
  logic                            do_commit;
  logic [BIN_W-1:0]                conv_bin;

  // ---------------------------------------------------------------- write check
  assign idx_legal = (int'(conf_selected_index) < CONF_NUM);
  assign wr_idx    = idx_legal ? conf_selected_index : '0;

  always_comb begin
    nibbles_ok = 1'b1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (!nib_is_bcd(conf_selected_new_value[4*d +: 4])) begin
        nibbles_ok = 1'b0;
      end
    end
  end

  assign wr_accept = conf_selected_set && idx_legal && nibbles_ok;

`ifdef CONF_BANK_RANGE_EN
  // Raw unsigned compare is ordered correctly because every digit is <= 9.
  always_comb begin
    store_val = conf_selected_new_value;
    if (conf_selected_new_value < CONF_MIN[wr_idx]) begin
      store_val = CONF_MIN[wr_idx];
    end else if (conf_selected_new_value > CONF_MAX[wr_idx]) begin
      store_val = CONF_MAX[wr_idx];
    end
  end
`else
  assign store_val = conf_selected_new_value;
`endif

  // ---------------------------------------------------------- dirty arbitration
  // Lowest dirty index wins: scan downward so the last hit is the smallest.
  always_comb begin
    pick_idx = '0;
    for (int k = CONF_NUM - 1; k >= 0; k--) begin
      if (dirty[k]) begin
        pick_idx = IDX_W'(k);
      end
    end
  end

  // ------------------------------------------------------------- FSM: register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // ----------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (|dirty) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_CONV;
      ST_CONV:   if (conv_done) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- FSM: outputs
  always_comb begin
    do_pick    = (state == ST_IDLE) && (|dirty);
    conv_start = (state == ST_LOAD);
    do_commit  = (state == ST_COMMIT);
  end

  // ------------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_mem             <= CONF_DEFAULT;
      bin_mem             <= '0;
      dirty               <= '1;
      cur_idx             <= '0;
      conf_selected_value <= '0;
      conf_valid          <= 1'b0;
      conf_err            <= 1'b0;
    end else if (ce) begin
      conf_selected_value <= idx_legal ? bcd_mem[conf_selected_index] : '0;
      conf_valid          <= (dirty == '0) && (state == ST_IDLE);

      if (do_pick) begin
        cur_idx <= pick_idx;
      end
      if (do_commit) begin
        bin_mem[cur_idx] <= conv_bin;
      end

      // The pick clears its bit from the pre-write vector; a write on the
      // same cycle (even to the picked entry) sets its bit afterwards so it
      // survives and forces another pass.
      begin
        logic [CONF_NUM-1:0] dirty_n;
        dirty_n = dirty;
        if (do_pick) begin
          dirty_n[pick_idx] = 1'b0;
        end
        if (wr_accept) begin
          dirty_n[wr_idx] = 1'b1;
        end
        dirty <= dirty_n;
      end

      if (conf_selected_set) begin
        if (wr_accept) begin
          bcd_mem[wr_idx] <= store_val;
          conf_err        <= 1'b0;
        end else begin
          conf_err        <= 1'b1;
        end
      end
    end
  end

  bcd_to_bin_seq #(
    .DIGITS (BCD_DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .start (conv_start),
    .bcd   (bcd_mem[cur_idx]),
    .done  (conv_done),
    .bin   (conv_bin)
  );

  assign conf_bin = bin_mem;

endmodule

`default_nettype wire

// File: tb/tb_conf_bank.sv
// ============================================================================
// Module      : tb_conf_bank
// Description : Directed self-checking bench for conf_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conf_bank;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic [2:0]   conf_selected_index;
  logic [23:0]  conf_selected_value;
  logic [23:0]  conf_selected_new_value;
  logic         conf_selected_set;
  logic [99:0]  conf_bin;
  logic         conf_valid;
  logic         conf_err;

  int compared   = 0;
  int mismatched = 0;

  conf_bank dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ce                      (ce),
    .conf_selected_index     (conf_selected_index),
    .conf_selected_value     (conf_selected_value),
    .conf_selected_new_value (conf_selected_new_value),
    .conf_selected_set       (conf_selected_set),
    .conf_bin                (conf_bin),
    .conf_valid              (conf_valid),
    .conf_err                (conf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] bin_of(input int k);
    return {12'd0, conf_bin[k*20 +: 20]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_max_sel;
  logic [31:0] exp_max_bin;

  initial begin
`ifdef CONF_BANK_RANGE_EN
    exp_max_sel = 32'h001000;
    exp_max_bin = 32'd1000;
`else
    exp_max_sel = 32'h999999;
    exp_max_bin = 32'd999999;
`endif
    rst_n = 1'b0; ce = 1'b1; conf_selected_index = 3'd0;
    conf_selected_new_value = 24'h0; conf_selected_set = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", {31'd0, conf_valid}, 32'd0);
    chk("rst_err",   {31'd0, conf_err},   32'd0);
    chk("rst_sel",   {8'd0, conf_selected_value}, 32'd0);
    chk("rst_bin0",  bin_of(0), 32'd0);
    chk("rst_bin4",  bin_of(4), 32'd0);

    // Initial conversion of all five defaults: 45 cycles + registered flag
    rst_n = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk("boot_valid_low", {31'd0, conf_valid}, 32'd0);
    end
    tick();
    chk("boot_valid_high", {31'd0, conf_valid}, 32'd1);
    chk("boot_bin0", bin_of(0), 32'd100);
    chk("boot_bin1", bin_of(1), 32'd3);
    chk("boot_bin2", bin_of(2), 32'd1);
    chk("boot_bin3", bin_of(3), 32'd3);
    chk("boot_bin4", bin_of(4), 32'd7);
    chk("boot_sel0", {8'd0, conf_selected_value}, 32'h000100);

    // Write entry 0 = 250
    conf_selected_index = 3'd0; conf_selected_new_value = 24'h000250; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    chk("wr0_sel_old", {8'd0, conf_selected_value}, 32'h000100);
    tick();
    chk("wr0_sel_new", {8'd0, conf_selected_value}, 32'h000250);
    chk("wr0_valid_low", {31'd0, conf_valid}, 32'd0);
    chk("wr0_bin_old", bin_of(0), 32'd100);
    repeat (7) tick();
    chk("wr0_bin_still_old", bin_of(0), 32'd100);
    tick();
    chk("wr0_bin_new", bin_of(0), 32'd250);
    chk("wr0_valid_commit", {31'd0, conf_valid}, 32'd0);
    tick();
    chk("wr0_valid_high", {31'd0, conf_valid}, 32'd1);

    // Illegal nibble then a valid write
    conf_selected_index = 3'd1; conf_selected_new_value = 24'h00012A; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    chk("bad_nib_err", {31'd0, conf_err}, 32'd1);
    tick();
    chk("bad_nib_sel", {8'd0, conf_selected_value}, 32'h000003);
    chk("bad_nib_valid", {31'd0, conf_valid}, 32'd1);
    conf_selected_new_value = 24'h000042; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    chk("good_clr_err", {31'd0, conf_err}, 32'd0);
    repeat (9) tick();
    chk("good_bin1", bin_of(1), 32'd42);
    tick();
    chk("good_valid", {31'd0, conf_valid}, 32'd1);
    chk("good_sel1", {8'd0, conf_selected_value}, 32'h000042);

    // Out-of-range index
    conf_selected_index = 3'd6; conf_selected_new_value = 24'h000011; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    chk("idx6_err", {31'd0, conf_err}, 32'd1);
    tick();
    chk("idx6_sel", {8'd0, conf_selected_value}, 32'd0);
    chk("idx6_valid", {31'd0, conf_valid}, 32'd1);

    // Rewrite of entry 2 during its third conversion step
    conf_selected_index = 3'd2; conf_selected_new_value = 24'h000005; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    repeat (4) tick();
    conf_selected_new_value = 24'h000009; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    repeat (4) tick();
    chk("ovl_bin_stale", bin_of(2), 32'd5);
    chk("ovl_valid_low", {31'd0, conf_valid}, 32'd0);
    repeat (9) tick();
    chk("ovl_bin_final", bin_of(2), 32'd9);
    tick();
    chk("ovl_valid_high", {31'd0, conf_valid}, 32'd1);
    chk("ovl_err_clr", {31'd0, conf_err}, 32'd0);
    chk("ovl_sel2", {8'd0, conf_selected_value}, 32'h000009);

    // Clock enable low: nothing moves, strobe ignored
    ce = 1'b0; conf_selected_index = 3'd3; conf_selected_new_value = 24'h000008; conf_selected_set = 1'b1;
    repeat (3) tick();
    chk("ce0_sel_hold", {8'd0, conf_selected_value}, 32'h000009);
    chk("ce0_err_hold", {31'd0, conf_err}, 32'd0);
    conf_selected_set = 1'b0; ce = 1'b1;
    tick();
    chk("ce1_sel3", {8'd0, conf_selected_value}, 32'h000003);
    chk("ce1_valid", {31'd0, conf_valid}, 32'd1);
    repeat (10) tick();
    chk("ce1_bin3", bin_of(3), 32'd3);

    // Largest BCD value (clamped when the range option is built in)
    conf_selected_index = 3'd0; conf_selected_new_value = 24'h999999; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    tick();
    chk("max_sel", {8'd0, conf_selected_value}, exp_max_sel);
    chk("max_err", {31'd0, conf_err}, 32'd0);
    repeat (8) tick();
    chk("max_bin0", bin_of(0), exp_max_bin);

    // Reset in the middle of a conversion
    conf_selected_index = 3'd4; conf_selected_new_value = 24'h000011; conf_selected_set = 1'b1;
    tick();
    conf_selected_set = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, conf_valid}, 32'd0);
    chk("mid_rst_bin4", bin_of(4), 32'd0);
    chk("mid_rst_sel", {8'd0, conf_selected_value}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (46) tick();
    chk("rerun_valid", {31'd0, conf_valid}, 32'd1);
    chk("rerun_bin0", bin_of(0), 32'd100);
    chk("rerun_bin4", bin_of(4), 32'd7);
    chk("rerun_sel4", {8'd0, conf_selected_value}, 32'h000007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
